// File: rtl/cop0_info.sv
`default_nettype none
// ============================================================================
// Module      : cop0_info (package)
// Description : CP0 register numbering, write masks, reset values and record
//               types shared by the CP0 register file and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
package cop0_info;

  // Register numbers and selects of the implemented CP0 registers
  localparam logic [4:0] RD_BADVADDR  = 5'd8;
  localparam logic [4:0] RD_COUNT     = 5'd9;
  localparam logic [4:0] RD_COMPARE   = 5'd11;
  localparam logic [4:0] RD_STATUS    = 5'd12;
  localparam logic [4:0] RD_CAUSE     = 5'd13;
  localparam logic [4:0] RD_EPC       = 5'd14;
  localparam logic [4:0] RD_EBASE     = 5'd15;
  localparam logic [4:0] RD_LLADDR    = 5'd17;
  localparam logic [4:0] RD_ERROREPC  = 5'd30;

  localparam logic [2:0] SEL_BADVADDR = 3'd0;
  localparam logic [2:0] SEL_COUNT    = 3'd0;
  localparam logic [2:0] SEL_COMPARE  = 3'd0;
  localparam logic [2:0] SEL_STATUS   = 3'd0;
  localparam logic [2:0] SEL_CAUSE    = 3'd0;
  localparam logic [2:0] SEL_EPC      = 3'd0;
  localparam logic [2:0] SEL_EBASE    = 3'd1;
  localparam logic [2:0] SEL_LLADDR   = 3'd0;
  localparam logic [2:0] SEL_ERROREPC = 3'd0;

  // Combined {rd, sel} decode keys
  localparam logic [7:0] KEY_BADVADDR = {RD_BADVADDR, SEL_BADVADDR};
  localparam logic [7:0] KEY_COUNT    = {RD_COUNT,    SEL_COUNT};
  localparam logic [7:0] KEY_COMPARE  = {RD_COMPARE,  SEL_COMPARE};
  localparam logic [7:0] KEY_STATUS   = {RD_STATUS,   SEL_STATUS};
  localparam logic [7:0] KEY_CAUSE    = {RD_CAUSE,    SEL_CAUSE};
  localparam logic [7:0] KEY_EPC      = {RD_EPC,      SEL_EPC};
  localparam logic [7:0] KEY_EBASE    = {RD_EBASE,    SEL_EBASE};
  localparam logic [7:0] KEY_LLADDR   = {RD_LLADDR,   SEL_LLADDR};
  localparam logic [7:0] KEY_ERROREPC = {RD_ERROREPC, SEL_ERROREPC};

  // Software-writable bits of the masked registers
  localparam logic [31:0] STATUS_WMASK = 32'hF040_FF17;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0080_0300;
  localparam logic [31:0] EBASE_WMASK  = 32'h3FFF_F000;

  // Reset values: boot-exception vectors and error level set
  localparam logic [31:0] STATUS_RESET = 32'h0040_0004;
  localparam logic [31:0] EBASE_RESET  = 32'h8000_0000;

  typedef struct packed {
    logic [3:0] cu;
    logic       rp;
    logic       fr;
    logic       re;
    logic       mx;
    logic       px;
    logic       bev;
    logic       ts;
    logic       sr;
    logic       nmi;
    logic       rsvd0;
    logic [1:0] impl;
    logic [7:0] im;
    logic       kx;
    logic       sx;
    logic       ux;
    logic       um;
    logic       r0;
    logic       erl;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    logic       bd;
    logic       ti;
    logic [1:0] ce;
    logic       dc;
    logic       pci;
    logic [1:0] rsvd0;
    logic       iv;
    logic       wp;
    logic [5:0] rsvd1;
    logic [7:0] ip;
    logic       rsvd2;
    logic [4:0] exc_code;
    logic [1:0] rsvd3;
  } cause_t;

  typedef struct packed {
    logic        one;
    logic        zero;
    logic [17:0] base;
    logic [1:0]  rsvd0;
    logic [9:0]  cpu_num;
  } ebase_t;

  typedef struct packed {
    logic        exception_happen;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic        in_bd;
    logic        load_addr;
    logic [31:0] badvaddr;
    logic        load_ce;
    logic [1:0]  ce;
  } cop0_exc_data_t;

  typedef struct packed {
    logic [31:0] epc;
    logic [31:0] error_epc;
    status_t     status;
    ebase_t      ebase;
  } cop0_excreg_t;

  // Build the {rd, sel} decode key
  function automatic logic [7:0] cop0_key(input logic [4:0] rd, input logic [2:0] sel);
    return {rd, sel};
  endfunction

  // Interrupt request: enabled, not in exception/error level, and unmasked pending
  function automatic logic cop0_int_pending(input status_t s, input cause_t c);
    return s.ie & ~s.exl & ~s.erl & (|(c.ip & s.im));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cop0_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : cop0_regfile_if
// Description : Pipeline-side bundle of the CP0 register file: MTC0/MFC0,
//               exception/ERET/LL commits, interrupt lines and feedback.
// Revision    : 1.0 - initial release
// ============================================================================
interface cop0_regfile_if;
  import cop0_info::*;

  logic           we;
  logic [4:0]     wr_rd;
  logic [2:0]     wr_sel;
  logic [31:0]    wdata;
  logic [4:0]     rd_rd;
  logic [2:0]     rd_sel;
  logic [31:0]    rdata;
  cop0_exc_data_t exc;
  logic           eret;
  logic           ll_we;
  logic [31:0]    ll_addr;
  logic [5:0]     hw_int;
  cop0_excreg_t   excreg;
  logic           int_req;

  modport master (
    output we, wr_rd, wr_sel, wdata, rd_rd, rd_sel, exc, eret, ll_we, ll_addr, hw_int,
    input  rdata, excreg, int_req
  );

  modport slave (
    input  we, wr_rd, wr_sel, wdata, rd_rd, rd_sel, exc, eret, ll_we, ll_addr, hw_int,
    output rdata, excreg, int_req
  );

endinterface
`default_nettype wire

// File: rtl/cop0_regfile_timer.sv
`default_nettype none
// ============================================================================
// Module      : cop0_timer
// Description : CP0 Count/Compare pair. Count advances every second cycle;
//               TI latches when an increment lands on Compare.
// Revision    : 1.0 - initial release
// ============================================================================
module cop0_timer (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        count_we,
  input  wire logic        compare_we,
  input  wire logic [31:0] wdata,
  output logic      [31:0] count,
  output logic      [31:0] compare,
  output logic             ti
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_toggle;
  logic        r_ti;
  logic [31:0] w_count_inc;

  assign w_count_inc = r_count + 32'd1;

  // Half-rate counter; software writes override the increment and clear TI
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_compare <= '0;
      r_toggle  <= 1'b0;
      r_ti      <= 1'b0;
    end else begin
      if (count_we) begin
        r_count  <= wdata;
        r_toggle <= 1'b0;
      end else begin
        r_toggle <= ~r_toggle;
        if (r_toggle) begin
          r_count <= w_count_inc;
        end
      end

      if (compare_we) begin
        r_compare <= wdata;
      end

      if (compare_we) begin
        r_ti <= 1'b0;
      end else if (!count_we && r_toggle && (w_count_inc == r_compare)) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule
`default_nettype wire

// File: rtl/cop0_regfile.sv
`default_nettype none
// ============================================================================
// Module      : cop0_regfile
// Description : Architectural CP0 register storage. Merges MTC0 writes,
//               exception and ERET commits, LL address capture, interrupt
//               sampling and the Count/Compare timer.
// Revision    : 1.0 - initial release
// ============================================================================
import cop0_info::*;

module cop0_regfile (
  input  wire logic      clk,
  input  wire logic      rst_n,
  cop0_regfile_if.slave  bus
);

  status_t     r_status;
  cause_t      r_cause;
  ebase_t      r_ebase;
  logic [31:0] r_epc;
  logic [31:0] r_error_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_lladdr;

  status_t     w_status_nxt;
  cause_t      w_cause_nxt;
  logic [31:0] w_epc_nxt;
  cause_t      w_cause_rd;
  logic [31:0] w_rdata;
  logic [7:0]  w_wr_key;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_wr_ebase;
  logic        w_wr_lladdr;
  logic        w_wr_error_epc;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;

  assign w_wr_key       = cop0_key(bus.wr_rd, bus.wr_sel);
  assign w_wr_status    = bus.we && (w_wr_key == KEY_STATUS);
  assign w_wr_cause     = bus.we && (w_wr_key == KEY_CAUSE);
  assign w_wr_epc       = bus.we && (w_wr_key == KEY_EPC);
  assign w_wr_ebase     = bus.we && (w_wr_key == KEY_EBASE);
  assign w_wr_lladdr    = bus.we && (w_wr_key == KEY_LLADDR);
  assign w_wr_error_epc = bus.we && (w_wr_key == KEY_ERROREPC);
  assign w_wr_count     = bus.we && (w_wr_key == KEY_COUNT);
  assign w_wr_compare   = bus.we && (w_wr_key == KEY_COMPARE);

  cop0_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_we   (w_wr_count),
    .compare_we (w_wr_compare),
    .wdata      (bus.wdata),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );

  // Next-state merge: later assignments win, giving exception > ERET > MTC0
  always_comb begin
    w_status_nxt = r_status;
    w_cause_nxt  = r_cause;
    w_epc_nxt    = r_epc;

    if (w_wr_status) begin
      w_status_nxt = status_t'((r_status & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK));
    end
    if (w_wr_cause) begin
      w_cause_nxt = cause_t'((r_cause & ~CAUSE_WMASK) | (bus.wdata & CAUSE_WMASK));
    end
    if (w_wr_epc) begin
      w_epc_nxt = bus.wdata;
    end

    // Hardware interrupt lines and timer are sampled every cycle
    w_cause_nxt.ip[7:2] = {bus.hw_int[5] | w_ti, bus.hw_int[4:0]};

    if (bus.eret) begin
      if (r_status.erl) begin
        w_status_nxt.erl = 1'b0;
      end else begin
        w_status_nxt.exl = 1'b0;
      end
    end

    if (bus.exc.exception_happen) begin
      w_status_nxt.exl     = 1'b1;
      w_cause_nxt.exc_code = bus.exc.exc_code;
      // A nested exception keeps the original return point
      if (!r_status.exl) begin
        w_epc_nxt      = bus.exc.epc;
        w_cause_nxt.bd = bus.exc.in_bd;
      end
      if (bus.exc.load_ce) begin
        w_cause_nxt.ce = bus.exc.ce;
      end
    end
  end

  // Architectural register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status    <= status_t'(STATUS_RESET);
      r_cause     <= '0;
      r_ebase     <= ebase_t'(EBASE_RESET);
      r_epc       <= '0;
      r_error_epc <= '0;
      r_badvaddr  <= '0;
      r_lladdr    <= '0;
    end else begin
      r_status <= w_status_nxt;
      r_cause  <= w_cause_nxt;
      r_epc    <= w_epc_nxt;
      if (w_wr_ebase) begin
        r_ebase <= ebase_t'((r_ebase & ~EBASE_WMASK) | (bus.wdata & EBASE_WMASK));
      end
      if (w_wr_error_epc) begin
        r_error_epc <= bus.wdata;
      end
      if (bus.exc.exception_happen && bus.exc.load_addr) begin
        r_badvaddr <= bus.exc.badvaddr;
      end
      // MTC0 to LLAddr takes precedence over the LL capture
      if (w_wr_lladdr) begin
        r_lladdr <= bus.wdata;
      end else if (bus.ll_we) begin
        r_lladdr <= bus.ll_addr;
      end
    end
  end

  // MFC0 read mux; Cause shows the live timer flag
  always_comb begin
    w_cause_rd    = r_cause;
    w_cause_rd.ti = r_cause.ti | w_ti;
    w_rdata       = '0;
    case (cop0_key(bus.rd_rd, bus.rd_sel))
      KEY_BADVADDR: w_rdata = r_badvaddr;
      KEY_COUNT:    w_rdata = w_count;
      KEY_COMPARE:  w_rdata = w_compare;
      KEY_STATUS:   w_rdata = r_status;
      KEY_CAUSE:    w_rdata = w_cause_rd;
      KEY_EPC:      w_rdata = r_epc;
      KEY_EBASE:    w_rdata = r_ebase;
      KEY_LLADDR:   w_rdata = r_lladdr;
      KEY_ERROREPC: w_rdata = r_error_epc;
      default:      w_rdata = '0;
    endcase
  end

  assign bus.rdata            = w_rdata;
  assign bus.excreg.epc       = r_epc;
  assign bus.excreg.error_epc = r_error_epc;
  assign bus.excreg.status    = r_status;
  assign bus.excreg.ebase     = r_ebase;
  assign bus.int_req          = cop0_int_pending(r_status, r_cause);

endmodule
`default_nettype wire

// File: tb/tb_cop0_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_cop0_regfile
// Description : Self-checking bench for cop0_regfile: directed scenarios plus
//               randomized traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cop0_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cop0_regfile_if bus();

  cop0_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_status, m_cause, m_epc, m_errorepc, m_badvaddr, m_ebase, m_lladdr;
  logic [31:0] m_count, m_compare;
  logic        m_ti, m_phase;

  task automatic model_reset();
    m_status = 32'h0040_0004; m_cause = 0; m_epc = 0; m_errorepc = 0;
    m_badvaddr = 0; m_ebase = 32'h8000_0000; m_lladdr = 0;
    m_count = 0; m_compare = 0; m_ti = 0; m_phase = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] rd, input logic [2:0] sel);
    case ({rd, sel})
      {5'd8,  3'd0}: return m_badvaddr;
      {5'd9,  3'd0}: return m_count;
      {5'd11, 3'd0}: return m_compare;
      {5'd12, 3'd0}: return m_status;
      {5'd13, 3'd0}: return m_cause | {1'b0, m_ti, 30'd0};
      {5'd14, 3'd0}: return m_epc;
      {5'd15, 3'd1}: return m_ebase;
      {5'd17, 3'd0}: return m_lladdr;
      {5'd30, 3'd0}: return m_errorepc;
      default:       return 32'd0;
    endcase
  endfunction

  function automatic logic model_irq();
    return m_status[0] && !m_status[1] && !m_status[2] && ((m_cause[15:8] & m_status[15:8]) != 0);
  endfunction

  // Apply one clock edge of architectural rules to the model
  task automatic model_step();
    logic [7:0]  k;
    logic [31:0] n_status, n_cause, n_epc, n_count, n_compare;
    logic        n_ti, n_phase, w;
    k = {bus.wr_rd, bus.wr_sel};
    w = bus.we;
    n_status = m_status; n_cause = m_cause; n_epc = m_epc;
    n_count = m_count; n_compare = m_compare; n_ti = m_ti; n_phase = m_phase;
    if (w && k == {5'd12, 3'd0}) n_status = (m_status & ~32'hF040_FF17) | (bus.wdata & 32'hF040_FF17);
    if (w && k == {5'd13, 3'd0}) n_cause = (m_cause & ~32'h0080_0300) | (bus.wdata & 32'h0080_0300);
    if (w && k == {5'd14, 3'd0}) n_epc = bus.wdata;
    if (w && k == {5'd15, 3'd1}) m_ebase = (m_ebase & ~32'h3FFF_F000) | (bus.wdata & 32'h3FFF_F000);
    if (w && k == {5'd30, 3'd0}) m_errorepc = bus.wdata;
    if (w && k == {5'd17, 3'd0}) m_lladdr = bus.wdata;
    else if (bus.ll_we) m_lladdr = bus.ll_addr;
    n_cause[15:10] = {bus.hw_int[5] | m_ti, bus.hw_int[4:0]};
    if (bus.eret) begin
      if (m_status[2]) n_status[2] = 1'b0;
      else n_status[1] = 1'b0;
    end
    if (bus.exc.exception_happen) begin
      n_status[1] = 1'b1;
      n_cause[6:2] = bus.exc.exc_code;
      if (!m_status[1]) begin
        n_epc = bus.exc.epc;
        n_cause[31] = bus.exc.in_bd;
      end
      if (bus.exc.load_addr) m_badvaddr = bus.exc.badvaddr;
      if (bus.exc.load_ce) n_cause[29:28] = bus.exc.ce;
    end
    if (w && k == {5'd9, 3'd0}) begin
      n_count = bus.wdata; n_phase = 1'b0;
    end else begin
      n_phase = !m_phase;
      if (m_phase) begin
        n_count = m_count + 1;
        if (n_count == m_compare) n_ti = 1'b1;
      end
    end
    if (w && k == {5'd11, 3'd0}) begin
      n_compare = bus.wdata; n_ti = 1'b0;
    end
    m_status = n_status; m_cause = n_cause; m_epc = n_epc;
    m_count = n_count; m_compare = n_compare; m_ti = n_ti; m_phase = n_phase;
  endtask

  task automatic idle_inputs();
    bus.we = 0; bus.wr_rd = 0; bus.wr_sel = 0; bus.wdata = 0;
    bus.exc = '0; bus.eret = 0; bus.ll_we = 0; bus.ll_addr = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic mtc0(input logic [4:0] rd, input logic [2:0] sel, input logic [31:0] d);
    bus.we = 1; bus.wr_rd = rd; bus.wr_sel = sel; bus.wdata = d;
    cycle();
    bus.we = 0;
  endtask

  task automatic mfc0(input logic [4:0] rd, input logic [2:0] sel, output logic [31:0] v);
    bus.rd_rd = rd; bus.rd_sel = sel;
    #1;
    v = bus.rdata;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    idle_inputs(); bus.hw_int = 0; bus.rd_rd = 0; bus.rd_sel = 0;
    rst_n = 1'b0;
    model_reset();
    #23;
    rst_n = 1'b1;
    mfc0(12, 0, v); checks++;
    if (v !== 32'h0040_0004) begin errors++; $display("FAIL reset_status: got %h exp 00400004", v); end
    mfc0(15, 1, v); checks++;
    if (v !== 32'h8000_0000) begin errors++; $display("FAIL reset_ebase: got %h exp 80000000", v); end
    mfc0(13, 0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h exp 00000000", v); end
    checks++;
    if (bus.int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req: got %b exp 0", bus.int_req); end
    cycle();
  endtask

  task automatic test_status_mask();
    logic [31:0] v;
    mtc0(12, 0, 32'hFFFF_FFFF);
    mfc0(12, 0, v); checks++;
    if (v !== 32'hF040_FF17) begin errors++; $display("FAIL status_mask: got %h exp f040ff17", v); end
    mtc0(15, 1, 32'hFFFF_FFFF);
    mfc0(15, 1, v); checks++;
    if (v !== 32'hBFFF_F000) begin errors++; $display("FAIL ebase_mask: got %h exp bffff000", v); end
    mtc0(8, 0, 32'h1111_1111);
    mfc0(8, 0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL badvaddr_ro: got %h exp 00000000", v); end
    mtc0(5, 0, 32'hFFFF_FFFF);
    mfc0(5, 0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h exp 00000000", v); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    mtc0(12, 0, 32'h0000_8001);
    mtc0(11, 0, 32'd10);
    mtc0(9, 0, 32'd0);
    for (int i = 0; i < 20; i++) cycle();
    mfc0(9, 0, v); checks++;
    if (v !== 32'd10) begin errors++; $display("FAIL timer_count: got %h exp 0000000a", v); end
    mfc0(13, 0, v); checks++;
    if (v !== 32'h4000_0000) begin errors++; $display("FAIL timer_ti_set: got %h exp 40000000", v); end
    checks++;
    if (bus.int_req !== 1'b0) begin errors++; $display("FAIL timer_irq_early: got %b exp 0", bus.int_req); end
    cycle();
    mfc0(13, 0, v); checks++;
    if (v !== 32'h4000_8000) begin errors++; $display("FAIL timer_ip7: got %h exp 40008000", v); end
    checks++;
    if (bus.int_req !== 1'b1) begin errors++; $display("FAIL timer_irq: got %b exp 1", bus.int_req); end
    mtc0(11, 0, 32'd1000);
    mfc0(13, 0, v); checks++;
    if (v !== 32'h0000_8000) begin errors++; $display("FAIL timer_ti_clear: got %h exp 00008000", v); end
    checks++;
    if (bus.int_req !== 1'b1) begin errors++; $display("FAIL timer_irq_hold: got %b exp 1", bus.int_req); end
    cycle();
    checks++;
    if (bus.int_req !== 1'b0) begin errors++; $display("FAIL timer_irq_drop: got %b exp 0", bus.int_req); end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    bus.exc = '0;
    bus.exc.exception_happen = 1; bus.exc.epc = 32'h8000_0100; bus.exc.in_bd = 1;
    bus.exc.exc_code = 5'd4; bus.exc.load_addr = 1; bus.exc.badvaddr = 32'h1234_5679;
    cycle();
    bus.exc = '0;
    mfc0(14, 0, v); checks++;
    if (v !== 32'h8000_0100) begin errors++; $display("FAIL exc_epc: got %h exp 80000100", v); end
    mfc0(13, 0, v); checks++;
    if (v !== 32'h8000_0010) begin errors++; $display("FAIL exc_cause: got %h exp 80000010", v); end
    mfc0(8, 0, v); checks++;
    if (v !== 32'h1234_5679) begin errors++; $display("FAIL exc_badvaddr: got %h exp 12345679", v); end
    mfc0(12, 0, v); checks++;
    if (v !== 32'h0000_8003) begin errors++; $display("FAIL exc_status: got %h exp 00008003", v); end
    checks++;
    if (bus.excreg.epc !== 32'h8000_0100 || bus.excreg.status.exl !== 1'b1) begin
      errors++; $display("FAIL exc_excreg: got epc %h exl %b exp 80000100 1", bus.excreg.epc, bus.excreg.status.exl);
    end
    bus.exc.exception_happen = 1; bus.exc.epc = 32'h0000_0200; bus.exc.exc_code = 5'd5;
    cycle();
    bus.exc = '0;
    mfc0(14, 0, v); checks++;
    if (v !== 32'h8000_0100) begin errors++; $display("FAIL nested_epc: got %h exp 80000100", v); end
    mfc0(13, 0, v); checks++;
    if (v !== 32'h8000_0014) begin errors++; $display("FAIL nested_cause: got %h exp 80000014", v); end
    mfc0(8, 0, v); checks++;
    if (v !== 32'h1234_5679) begin errors++; $display("FAIL nested_badvaddr: got %h exp 12345679", v); end
  endtask

  task automatic test_eret();
    logic [31:0] v;
    pulse_reset();
    cycle();
    bus.exc.exception_happen = 1; bus.exc.epc = 32'h0000_1000;
    cycle();
    bus.exc = '0;
    mfc0(12, 0, v); checks++;
    if (v !== 32'h0040_0006) begin errors++; $display("FAIL eret_pre: got %h exp 00400006", v); end
    bus.eret = 1; cycle(); bus.eret = 0;
    mfc0(12, 0, v); checks++;
    if (v !== 32'h0040_0002) begin errors++; $display("FAIL eret_first: got %h exp 00400002", v); end
    bus.eret = 1; cycle(); bus.eret = 0;
    mfc0(12, 0, v); checks++;
    if (v !== 32'h0040_0000) begin errors++; $display("FAIL eret_second: got %h exp 00400000", v); end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    mtc0(14, 0, 32'hDEAD_BEEF);
    @(negedge clk);
    rst_n = 1'b0;
    mfc0(14, 0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL async_epc: got %h exp 00000000", v); end
    mfc0(12, 0, v); checks++;
    if (v !== 32'h0040_0004) begin errors++; $display("FAIL async_status: got %h exp 00400004", v); end
    model_reset();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    bus.exc.exception_happen = 1; bus.exc.epc = 32'h40;
    mtc0(12, 0, 32'h0);
    bus.exc = '0;
    mfc0(12, 0, v); checks++;
    if (v !== 32'h0000_0002) begin errors++; $display("FAIL sim_exc_mtc0: got %h exp 00000002", v); end
    mtc0(9, 0, 32'h100);
    cycle();
    mtc0(9, 0, 32'h55);
    mfc0(9, 0, v); checks++;
    if (v !== 32'h55) begin errors++; $display("FAIL sim_count_write: got %h exp 00000055", v); end
    cycle();
    cycle();
    mfc0(9, 0, v); checks++;
    if (v !== 32'h56) begin errors++; $display("FAIL count_restart: got %h exp 00000056", v); end
    mtc0(9, 0, 32'hFFFF_FFFF);
    cycle();
    cycle();
    mfc0(9, 0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL count_wrap: got %h exp 00000000", v); end
    bus.ll_we = 1; bus.ll_addr = 32'hAAAA_0000;
    mtc0(17, 0, 32'h1111_2222);
    mfc0(17, 0, v); checks++;
    if (v !== 32'h1111_2222) begin errors++; $display("FAIL ll_vs_mtc0: got %h exp 11112222", v); end
    bus.ll_addr = 32'h3333_4444;
    cycle();
    bus.ll_we = 0;
    mfc0(17, 0, v); checks++;
    if (v !== 32'h3333_4444) begin errors++; $display("FAIL ll_write: got %h exp 33334444", v); end
  endtask

  task automatic test_random();
    logic [4:0]  rd_tab [11] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd17, 5'd30, 5'd5, 5'd12};
    logic [2:0]  sel_tab[11] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1};
    logic [31:0] v, e;
    int          r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 10);
      mfc0(rd_tab[r], sel_tab[r], v);
      e = model_read(rd_tab[r], sel_tab[r]);
      checks++;
      if (v !== e) begin errors++; $display("FAIL rand_read rd%0d sel%0d: got %h exp %h", rd_tab[r], sel_tab[r], v, e); end
      checks++;
      if (bus.int_req !== model_irq()) begin errors++; $display("FAIL rand_int_req: got %b exp %b", bus.int_req, model_irq()); end
      checks++;
      if (bus.excreg.epc !== m_epc || bus.excreg.status !== m_status ||
          bus.excreg.error_epc !== m_errorepc || bus.excreg.ebase !== m_ebase) begin
        errors++; $display("FAIL rand_excreg: got epc %h st %h exp epc %h st %h", bus.excreg.epc, bus.excreg.status, m_epc, m_status);
      end
      idle_inputs();
      bus.hw_int = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 10);
        bus.we = 1; bus.wr_rd = rd_tab[r]; bus.wr_sel = sel_tab[r]; bus.wdata = $urandom;
        if (r == 1 && $urandom_range(0, 1) == 1) bus.wdata = m_compare - 32'd3;
      end
      if ($urandom_range(0, 9) == 0) begin
        bus.exc.exception_happen = 1; bus.exc.exc_code = 5'($urandom_range(0, 31));
        bus.exc.epc = $urandom; bus.exc.in_bd = 1'($urandom_range(0, 1));
        bus.exc.load_addr = 1'($urandom_range(0, 1)); bus.exc.badvaddr = $urandom;
        bus.exc.load_ce = 1'($urandom_range(0, 1)); bus.exc.ce = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) bus.eret = 1;
      if ($urandom_range(0, 5) == 0) begin bus.ll_we = 1; bus.ll_addr = $urandom; end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_status_mask();
    test_timer();
    test_exception();
    test_eret();
    test_async_reset();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
